// File: rtl/bus_pkg.sv
// Shared definitions for the bus-to-UART transmit bridge.
// Optional even-parity framing is selected with the BRIDGE_PARITY_EN macro.
package bus_pkg;

    // Serial-bus slave address this bridge answers to.
    localparam logic [2:0] BRIDGE_SLAVE_ID = 3'd4;

    // 50 MHz system clock, 9600 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    // TX FSM encodings; PARITY is only reachable when BRIDGE_PARITY_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/bridge_fifo.sv
// Small synchronous FIFO between bus writes and the UART shifter.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter. Read data is first-word
// fall-through: rdata shows the head entry whenever empty is low.
module bridge_fifo
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_AW    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [FIFO_AW:0]      wr_ptr;
    logic [FIFO_AW:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  rd_fire;
    logic                  wr_fire;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign rd_fire = rd && !empty;
    // A write into a full FIFO still lands when the head leaves on the same edge.
    assign wr_fire = wr && (!full || rd_fire);
    assign rdata   = mem[rd_ptr[FIFO_AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[FIFO_AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bus_uart_bridge_tx.sv
// Bus-side transmit bridge (slave ID 4): buffers bus writes in a FIFO and
// sends each byte as a UART frame on tx_line, 8N1 by default or 8E1 when
// BRIDGE_PARITY_EN is defined.
//
// Handshake: the bus has no backpressure. Every s_wr_en pulse (s_wr_data
// valid for that cycle) is acknowledged by a one-cycle s_dv pulse on the
// following cycle, whether the byte was stored or dropped because the FIFO
// was full; dropped bytes set the sticky overflow flag instead.
module bus_uart_bridge_tx
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_AW      = 2,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 13
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_wr_en,
    input  logic [DATA_WIDTH-1:0] s_wr_data,
    output logic                  s_dv,
    output logic                  tx_line,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  overflow,
    output logic                  tx_busy,
    output logic [3:0]            state
);

    localparam int                IDX_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             st, st_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic                  tx_q, tx_n;
    logic                  pop;
    logic                  bit_done;
    logic [DATA_WIDTH-1:0] fifo_rdata;
`ifdef BRIDGE_PARITY_EN
    logic                  par_q, par_n;
`endif

    bridge_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .wr    (s_wr_en),
        .wdata (s_wr_data),
        .rd    (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_done = (cnt == CNT_LAST);
    assign tx_line  = tx_q;
    assign tx_busy  = (st != ST_IDLE);
    assign state    = {1'b0, st};

    // Next-state, baud timing and serial bit selection for the TX FSM.
    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        tx_n    = tx_q;
        pop     = 1'b0;
`ifdef BRIDGE_PARITY_EN
        par_n   = par_q;
`endif
        if (st != ST_IDLE) cnt_n = bit_done ? '0 : cnt + 1'b1;
        case (st)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_rdata;
`ifdef BRIDGE_PARITY_EN
                    par_n   = ^fifo_rdata;
`endif
                    tx_n    = 1'b0;
                    cnt_n   = '0;
                    st_n    = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    st_n  = ST_DATA;
                    idx_n = '0;
                    tx_n  = shift[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (idx == IDX_LAST) begin
`ifdef BRIDGE_PARITY_EN
                        st_n = ST_PARITY;
                        tx_n = par_q;
`else
                        st_n = ST_STOP;
                        tx_n = 1'b1;
`endif
                    end else begin
                        idx_n   = idx + 1'b1;
                        shift_n = shift >> 1;
                        tx_n    = shift_n[0];
                    end
                end
            end
`ifdef BRIDGE_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    st_n = ST_STOP;
                    tx_n = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                tx_n = 1'b1;
                if (bit_done) st_n = ST_IDLE;
            end
            default: begin
                st_n  = ST_IDLE;
                cnt_n = '0;
                tx_n  = 1'b1;
            end
        endcase
    end

    // TX FSM and datapath registers; reset abandons any frame and idles the line high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st    <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            tx_q  <= 1'b1;
`ifdef BRIDGE_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            st    <= st_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            tx_q  <= tx_n;
`ifdef BRIDGE_PARITY_EN
            par_q <= par_n;
`endif
        end
    end

    // Write acknowledge and sticky drop flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_dv     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            s_dv <= s_wr_en;
            if (s_wr_en && fifo_full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_uart_bridge_tx.sv
// Testbench for bus_uart_bridge_tx with CLKS_PER_BIT=4, FIFO_AW=2.
// Works for both framings; define BRIDGE_PARITY_EN for the 8E1 build.
module tb_bus_uart_bridge_tx;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef BRIDGE_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       s_wr_en = 1'b0;
    logic [7:0] s_wr_data = 8'h00;
    logic       s_dv, tx_line, fifo_full, fifo_empty, overflow, tx_busy;
    logic [3:0] state;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;
    vec_t tbl[6];

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0;
    longint     cyc = 0;
    longint     next_pop = 0;
    int         rd_idx = 0;
    int         rx_cnt = 0;
    logic [7:0] last_rx = 8'h00;
    logic       last_par = 1'b0;

    bus_uart_bridge_tx #(
        .DATA_WIDTH   (8),
        .FIFO_AW      (AW),
        .CLKS_PER_BIT (CPB),
        .CNT_W        (13)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_wr_en    (s_wr_en),
        .s_wr_data  (s_wr_data),
        .s_dv       (s_dv),
        .tx_line    (tx_line),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow),
        .tx_busy    (tx_busy),
        .state      (state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Expected line level for bit slot b of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && FRAME_BITS == 11) return ^d;
        return 1'b1;
    endfunction

    // Reference model: bounded queue; the transmitter takes the head whenever
    // it is free, and is free again one cycle after a full frame time.
    initial begin : ref_model
        logic pop_now;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_q.delete();
                exp_q.delete();
                m_ovf    = 1'b0;
                next_pop = 0;
                cyc      = 0;
            end else begin
                cyc++;
                pop_now = (m_q.size() > 0) && (cyc >= next_pop);
                if (pop_now) begin
                    exp_q.push_back(m_q.pop_front());
                    next_pop = cyc + FRAME_CYC + 1;
                end
                if (s_wr_en) begin
                    if (m_q.size() < DEPTH) m_q.push_back(s_wr_data);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    // UART line monitor and scoreboard: decodes frames at mid-bit.
    initial begin : monitor
        logic       prev;
        logic [10:0] bits;
        int         off;
        logic       ab;
        logic [7:0] rx;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev   = 1'b1;
                rd_idx = 0;
            end else if (prev && !tx_line) begin
                off  = 0;
                ab   = 1'b0;
                bits = '0;
                while (off < (FRAME_BITS - 1) * CPB + CPB / 2) begin
                    if (off % CPB == CPB / 2) bits[off / CPB] = tx_line;
                    @(negedge clk);
                    off++;
                    if (!rstn) begin
                        ab = 1'b1;
                        break;
                    end
                end
                if (ab) begin
                    rd_idx = 0;
                    prev   = 1'b1;
                end else begin
                    bits[FRAME_BITS-1] = tx_line;
                    rx = bits[8:1];
                    check("start_bit", 32'(bits[0]), 32'd0);
                    check("stop_bit", 32'(bits[FRAME_BITS-1]), 32'd1);
`ifdef BRIDGE_PARITY_EN
                    check("parity_bit", 32'(bits[9]), 32'(^rx));
                    last_par = bits[9];
`endif
                    if (rd_idx < exp_q.size()) begin
                        check("sb_byte", 32'(rx), 32'(exp_q[rd_idx]));
                        rd_idx++;
                    end else begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_unexpected: got frame %02h, want no frame", rx);
                    end
                    last_rx = rx;
                    rx_cnt++;
                    prev = tx_line;
                end
            end else begin
                prev = tx_line;
            end
        end
    end

    // Driver tasks (all start and end on a falling edge)
    task automatic write_byte(input logic [7:0] d);
        s_wr_en   = 1'b1;
        s_wr_data = d;
        @(negedge clk);
        s_wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (!(fifo_empty && !tx_busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'(fifo_empty && !tx_busy), 32'd1);
        check("sb_drain", 32'(rd_idx), 32'(exp_q.size()));
    endtask

    task automatic wait_state(input logic [3:0] s, input logic need_full, input int max_cyc);
        int n = 0;
        while (!(state == s && (!need_full || fifo_full)) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", 32'(state == s), 32'd1);
    endtask

    // Stimulus
    initial begin : main
        int dv_seen;
        int low_seen;
        int rx0;

        tbl = '{'{8'h07, 1'b1}, '{8'h03, 1'b0}, '{8'hFF, 1'b0},
                '{8'h80, 1'b1}, '{8'h00, 1'b0}, '{8'h5A, 1'b0}};

        // Reset values and quiet idle
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_dv", 32'(s_dv), 32'd0);
        check("rst_tx_line", 32'(tx_line), 32'd1);
        check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        rstn = 1'b1;
        dv_seen  = 0;
        low_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (s_dv) dv_seen++;
            if (!tx_line) low_seen++;
        end
        check("idle_dv_pulses", 32'(dv_seen), 32'd0);
        check("idle_tx_low", 32'(low_seen), 32'd0);
        check("idle_fifo_empty", 32'(fifo_empty), 32'd1);

        // Cycle-exact frame for 8'hA5
        write_byte(8'hA5);
        check("a5_dv", 32'(s_dv), 32'd1);
        check("a5_tx_before", 32'(tx_line), 32'd1);
        @(negedge clk);
        check("a5_dv_drop", 32'(s_dv), 32'd0);
        check("a5_state_start", 32'(state), 32'd1);
        for (int k = 0; k < FRAME_CYC; k++) begin
            check("a5_frame_bit", 32'(tx_line), 32'(frame_bit(8'hA5, k / CPB)));
            check("a5_busy", 32'(tx_busy), 32'd1);
            @(negedge clk);
        end
        check("a5_busy_fall", 32'(tx_busy), 32'd0);
        check("a5_state_idle", 32'(state), 32'd0);
        wait_drain(20);

        // Table of bytes with known parity
        foreach (tbl[i]) begin
            write_byte(tbl[i].data);
            wait_drain(FRAME_CYC + 20);
            check("tbl_byte", 32'(last_rx), 32'(tbl[i].data));
`ifdef BRIDGE_PARITY_EN
            check("tbl_parity", 32'(last_par), 32'(tbl[i].par));
`endif
        end

        // Five back-to-back writes fill the FIFO; a sixth is dropped
        rx0 = rx_cnt;
        for (int i = 1; i <= 5; i++) begin
            s_wr_en   = 1'b1;
            s_wr_data = 8'(i);
            @(negedge clk);
        end
        s_wr_en = 1'b0;
        check("fill_full", 32'(fifo_full), 32'd1);
        check("fill_no_ovf", 32'(overflow), 32'd0);
        write_byte(8'h06);
        check("drop_dv", 32'(s_dv), 32'd1);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_ovf_model", 32'(overflow), 32'(m_ovf));
        wait_drain(FRAME_CYC * 6 + 50);
        check("drop_frames", 32'(rx_cnt - rx0), 32'd5);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Write into a full FIFO on the same edge as the IDLE pop
        do_reset();
        check("reset_clears_ovf", 32'(overflow), 32'd0);
        rx0 = rx_cnt;
        for (int i = 0; i < 5; i++) begin
            s_wr_en   = 1'b1;
            s_wr_data = 8'(8'h11 + i);
            @(negedge clk);
        end
        s_wr_en = 1'b0;
        wait_state(4'd0, 1'b1, FRAME_CYC + 20);
        check("coinc_pre_full", 32'(fifo_full), 32'd1);
        write_byte(8'h16);
        check("coinc_full", 32'(fifo_full), 32'd1);
        check("coinc_no_ovf", 32'(overflow), 32'd0);
        check("coinc_started", 32'(state), 32'd1);
        wait_drain(FRAME_CYC * 7 + 50);
        check("coinc_frames", 32'(rx_cnt - rx0), 32'd6);

        // Reset in the middle of a frame
        do_reset();
        write_byte(8'h3C);
        wait_state(4'd2, 1'b0, 3 * CPB);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_tx_line", 32'(tx_line), 32'd1);
        check("midrst_empty", 32'(fifo_empty), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_state", 32'(state), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rx0      = rx_cnt;
        low_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (!tx_line) low_seen++;
        end
        check("midrst_no_residual", 32'(low_seen), 32'd0);
        write_byte(8'h81);
        wait_drain(FRAME_CYC + 20);
        check("midrst_new_byte", 32'(last_rx), 32'h81);
        check("midrst_frames", 32'(rx_cnt - rx0), 32'd1);

        // Randomised bursts against the reference model
        do_reset();
        for (int i = 0; i < 16; i++) begin
            write_byte(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 50)) @(negedge clk);
        end
        wait_drain(FRAME_CYC * 8 + 50);
        check("rand_overflow", 32'(overflow), 32'(m_ovf));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
